rgb2gray: RTL and testbench

RGB2GRAY -- requirements
Module: rgb2gray

---
 rtl/rgb2gray.sv | 120 ++++++++++++
 tb/tb_rgb2gray.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb2gray.sv
// rgb2gray: three-stage RGB to grey converter with valid/ready flow control.
// Define RGB2GRAY_ROUND_EN to round half up in S3 (default build truncates).
module rgb2gray #(
  parameter int ChannelWidth = 8,
  parameter int CoeffR = 77,
  parameter int CoeffG = 150,
  parameter int CoeffB = 29
) (
  input  logic                      clk_i,
  input  logic                      reset_ni,
  input  logic [3*ChannelWidth-1:0] data_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  output logic                      valid_o,
  output logic [ChannelWidth-1:0]   data_o,
  input  logic                      ready_i
);

  localparam int W  = ChannelWidth;
  localparam int PW = W + 8;
  localparam int SW = W + 10;

  localparam logic [PW-1:0] KR = PW'(CoeffR);
  localparam logic [PW-1:0] KG = PW'(CoeffG);
  localparam logic [PW-1:0] KB = PW'(CoeffB);

  if (CoeffR + CoeffG + CoeffB > 256) begin : g_sum_chk
    $error("rgb2gray: CoeffR+CoeffG+CoeffB must be <= 256");
  end
  if (CoeffR > 255 || CoeffG > 255 || CoeffB > 255) begin : g_q08_chk
    $error("rgb2gray: each coefficient must fit in Q0.8");
  end

  logic [W-1:0]  ch_r;
  logic [W-1:0]  ch_g;
  logic [W-1:0]  ch_b;

  logic          v1;
  logic          v2;
  logic          v3;
  logic [PW-1:0] p_r;
  logic [PW-1:0] p_g;
  logic [PW-1:0] p_b;
  logic [SW-1:0] sum;

  logic          load1;
  logic          load2;
  logic          load3;
  logic          in_fire;

  logic [SW-1:0] sum_adj;
  logic [W+1:0]  scaled;
  logic [W-1:0]  y_next;

  assign ch_r = data_i[3*W-1:2*W];
  assign ch_g = data_i[2*W-1:W];
  assign ch_b = data_i[W-1:0];

  // A stage may load when empty or when its content moves on this cycle.
  assign load3   = !v3 || ready_i;
  assign load2   = !v2 || load3;
  assign load1   = !v1 || load2;
  assign ready_o = load1;
  assign in_fire = valid_i && load1;
  assign valid_o = v3;

`ifdef RGB2GRAY_ROUND_EN
  assign sum_adj = sum + SW'(128);
`else
  assign sum_adj = sum;
`endif

  // Drop the Q0.8 fraction and clamp anything above full scale.
  assign scaled = sum_adj[SW-1:8];
  assign y_next = (|scaled[W+1:W]) ? '1 : scaled[W-1:0];

  // S1: per-channel weighted products.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      v1  <= 1'b0;
      p_r <= '0;
      p_g <= '0;
      p_b <= '0;
    end else if (load1) begin
      v1 <= in_fire;
      if (in_fire) begin
        p_r <= PW'(ch_r) * KR;
        p_g <= PW'(ch_g) * KG;
        p_b <= PW'(ch_b) * KB;
      end
    end
  end

  // S2: sum of the three products.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      v2  <= 1'b0;
      sum <= '0;
    end else if (load2) begin
      v2 <= v1;
      if (v1) begin
        sum <= SW'(p_r) + SW'(p_g) + SW'(p_b);
      end
    end
  end

  // S3: scaled, saturated grey sample held until taken downstream.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      v3     <= 1'b0;
      data_o <= '0;
    end else if (load3) begin
      v3 <= v2;
      if (v2) begin
        data_o <= y_next;
      end
    end
  end

endmodule

// File: tb/tb_rgb2gray.sv
// tb_rgb2gray: directed and random checks of the rgb2gray pipeline.
// Expected values follow RGB2GRAY_ROUND_EN when it is defined.
module tb_rgb2gray;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic [23:0] data_i;
  logic        valid_i;
  logic        ready_o;
  logic        valid_o;
  logic [7:0]  data_o;
  logic        ready_i;

  int checks = 0;
  int passes = 0;

  always #5 clk_i = ~clk_i;

  rgb2gray dut (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .data_i   (data_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .valid_o  (valid_o),
    .data_o   (data_o),
    .ready_i  (ready_i)
  );

  function automatic logic [7:0] gray(input logic [23:0] px);
    int s;
    s = int'(px[23:16]) * 77 + int'(px[15:8]) * 150 + int'(px[7:0]) * 29;
`ifdef RGB2GRAY_ROUND_EN
    s = s + 128;
`endif
    s = s >> 8;
    if (s > 255) s = 255;
    return 8'(s);
  endfunction

  function automatic logic [23:0] stall_px(input int i);
    return {8'(i * 25), 8'(200 - i * 13), 8'(i * 7 + 3)};
  endfunction

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset;
    reset_ni = 1'b0;
    valid_i  = 1'b0;
    ready_i  = 1'b1;
    data_i   = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if (valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_o);
    else passes++;
    checks++;
    if (data_o !== 8'd0) $display("FAIL reset_data: got %0d want 0", data_o);
    else passes++;
    reset_ni = 1'b1;
    #1;
    checks++;
    if (ready_o !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready_o);
    else passes++;
  endtask

  task automatic test_latency;
    logic ev;
    tick();
    ready_i = 1'b1;
    data_i  = 24'hFFFFFF;
    valid_i = 1'b1;
    checks++;
    if (ready_o !== 1'b1) $display("FAIL lat_ready: got %b want 1", ready_o);
    else passes++;
    tick();
    valid_i = 1'b0;
    data_i  = '0;
    for (int c = 1; c <= 3; c++) begin
      ev = (c == 3);
      checks++;
      if (valid_o !== ev)
        $display("FAIL lat_valid_c%0d: got %b want %b", c, valid_o, ev);
      else passes++;
      if (c < 3) tick();
    end
    checks++;
    if (data_o !== 8'd255) $display("FAIL lat_white: got %0d want 255", data_o);
    else passes++;
    tick();
    checks++;
    if (valid_o !== 1'b0) $display("FAIL lat_dup: got %b want 0", valid_o);
    else passes++;
  endtask

  task automatic test_back_to_back;
    logic [23:0] vec [7];
    logic [7:0]  exp [7];
    logic        ev;
    vec[0] = {8'd255, 8'd0,   8'd0};
    vec[1] = {8'd0,   8'd0,   8'd255};
    vec[2] = {8'd0,   8'd255, 8'd0};
    vec[3] = {8'd100, 8'd50,  8'd200};
    vec[4] = {8'd128, 8'd128, 8'd128};
    vec[5] = {8'd0,   8'd0,   8'd0};
    vec[6] = {8'd10,  8'd20,  8'd30};
`ifdef RGB2GRAY_ROUND_EN
    exp[0] = 8'd77;
    exp[1] = 8'd29;
`else
    exp[0] = 8'd76;
    exp[1] = 8'd28;
`endif
    exp[2] = 8'd149;
    exp[3] = 8'd82;
    exp[4] = 8'd128;
    exp[5] = 8'd0;
    exp[6] = 8'd18;
    ready_i = 1'b1;
    for (int k = 0; k < 11; k++) begin
      valid_i = (k < 7);
      data_i  = (k < 7) ? vec[k] : 24'd0;
      ev = (k >= 3) && (k < 10);
      checks++;
      if (valid_o !== ev)
        $display("FAIL b2b_valid_k%0d: got %b want %b", k, valid_o, ev);
      else passes++;
      if (ev) begin
        checks++;
        if (data_o !== exp[k-3])
          $display("FAIL b2b_data_%0d: got %0d want %0d", k - 3, data_o, exp[k-3]);
        else passes++;
      end
      tick();
    end
  endtask

  task automatic test_stall;
    int sent;
    int recv;
    int low_cycles;
    logic       hold;
    logic [7:0] held;
    sent = 0;
    recv = 0;
    low_cycles = 0;
    hold = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < 60 && recv < 10; cyc++) begin
      ready_i = !(cyc >= 2 && cyc < 8);
      valid_i = (sent < 10);
      data_i  = (sent < 10) ? stall_px(sent) : 24'd0;
      @(negedge clk_i);
      if (hold) begin
        checks++;
        if (valid_o !== 1'b1 || data_o !== held)
          $display("FAIL stall_hold: got %b/%0d want 1/%0d", valid_o, data_o, held);
        else passes++;
      end
      if (ready_o === 1'b0) begin
        low_cycles++;
        checks++;
        if (sent - recv != 3)
          $display("FAIL stall_full: got %0d held want 3", sent - recv);
        else passes++;
      end
      if (valid_o && ready_i) begin
        checks++;
        if (data_o !== gray(stall_px(recv)))
          $display("FAIL stall_out_%0d: got %0d want %0d", recv, data_o,
                   gray(stall_px(recv)));
        else passes++;
        recv++;
      end
      hold = valid_o && !ready_i;
      held = data_o;
      if (valid_i && ready_o) sent++;
      tick();
    end
    valid_i = 1'b0;
    checks++;
    if (recv != 10) $display("FAIL stall_count: got %0d want 10", recv);
    else passes++;
    checks++;
    if (low_cycles == 0) $display("FAIL stall_ready_low: got 0 cycles want >0");
    else passes++;
  endtask

  task automatic test_random;
    logic [7:0] q[$];
    logic [7:0] want;
    logic [7:0] held;
    logic       hold;
    logic       acc;
    int sent;
    int recv;
    sent = 0;
    recv = 0;
    hold = 1'b0;
    held = '0;
    acc  = 1'b0;
    valid_i = 1'b0;
    for (int cyc = 0; cyc < 20000 && recv < 1000; cyc++) begin
      ready_i = 1'($urandom % 2);
      if (acc || !valid_i) begin
        valid_i = (sent < 1000) ? 1'($urandom % 2) : 1'b0;
        data_i  = 24'($urandom);
      end
      @(negedge clk_i);
      if (hold) begin
        checks++;
        if (valid_o !== 1'b1 || data_o !== held)
          $display("FAIL rand_hold: got %b/%0d want 1/%0d", valid_o, data_o, held);
        else passes++;
      end
      if (valid_o && ready_i) begin
        checks++;
        if (q.size() == 0) begin
          $display("FAIL rand_extra: got %0d want none", data_o);
        end else begin
          want = q.pop_front();
          if (data_o !== want)
            $display("FAIL rand_out_%0d: got %0d want %0d", recv, data_o, want);
          else passes++;
        end
        recv++;
      end
      hold = valid_o && !ready_i;
      held = data_o;
      acc  = valid_i && ready_o;
      if (acc) begin
        q.push_back(gray(data_i));
        sent++;
      end
      tick();
    end
    valid_i = 1'b0;
    checks++;
    if (recv != 1000 || q.size() != 0)
      $display("FAIL rand_count: got %0d out %0d left want 1000/0", recv, q.size());
    else passes++;
  endtask

  task automatic test_reset_inflight;
    ready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      valid_i = 1'b1;
      data_i  = {8'd200, 8'd100, 8'(i * 40)};
      tick();
    end
    @(negedge clk_i);
    checks++;
    if (valid_o !== 1'b1 || ready_o !== 1'b0)
      $display("FAIL rst_full: got v%b r%b want v1 r0", valid_o, ready_o);
    else passes++;
    #2;
    reset_ni = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b0 || data_o !== 8'd0)
      $display("FAIL rst_async: got %b/%0d want 0/0", valid_o, data_o);
    else passes++;
    valid_i = 1'b0;
    ready_i = 1'b1;
    #1;
    reset_ni = 1'b1;
    tick();
    checks++;
    if (ready_o !== 1'b1) $display("FAIL rst_ready: got %b want 1", ready_o);
    else passes++;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (valid_o !== 1'b0)
        $display("FAIL rst_stale_%0d: got %b want 0", i, valid_o);
      else passes++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_stall();
    test_random();
    test_reset_inflight();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
